avalon_arbiter: RTL and testbench
=================================

// Module: avalon_arbiter
// PURPOSE
//  Shares the single Avalon-MM slave port of the counter peripheral (2-bit word address, 32-bit data,
//  fixed 1-cycle read latency) between NUM_MASTERS requesters. Round-robin arbitration per transfer.
//  Optional per-master lock gives atomic read-modify-write of the config register.
//  Sits between the CPU/DMA masters and the peripheral core; irq is passed through.
// PARAMETERS
//  NUM_MASTERS   2   requesters, 2..8
//  LOCK_TIMEOUT  16  idle cycles a lock owner may hold the lock before forced release, >=1
// PORTS
//  clk           in   1        clock
//  resetN        in   1        reset
//  mRead         in   N        per-master read strobe
//  mWrite        in   N        per-master write strobe
//  mAddress      in   N x 2    per-master word address
//  mDataIn       in   N x 32   per-master write data
//  mLock         in   N        hold grant across consecutive transfers
//  mWaitRequest  out  N        1 = request not accepted this cycle
//  mReadValid    out  N        read data valid, routed to the issuing master
//  mDataOut      out  32       read data, broadcast; qualified by mReadValid
//  sRead/sWrite  out  1        to slave
//  sAddress      out  2        to slave
//  sDataOut      out  32       write data to slave
//  sReadValid    in   1        from slave, exactly 1 cycle after sRead
//  sDataIn       in   32       read data from slave
//  sIrq          in   1        slave interrupt
//  irq           out  1        = sIrq, combinational
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low.
//  Reset values: state IDLE, ptr=N-1, rdPending=0, rdOwner=0, lockOwner=0, idleCnt=0.
//  Outputs during reset: mReadValid=0, lockTimeout=0. A read in flight at reset is dropped.
//  Request: req[i] = mRead[i]|mWrite[i]. If both strobes are set, only the write is forwarded.
//  Grant (combinational, same cycle):
//   - one-hot, searching from ptr+1 upward, mod N.
//   - mWaitRequest[i] = req[i] & ~grant[i].
//   - granted master's read/write/address/data are muxed to s*.
//   - no grant: sRead=sWrite=0, sAddress=0, sDataOut=0.
//  ptr <= granted index on every transfer, so master 0 wins first after reset.
//  Writes complete in the grant cycle.
//  Reads: on sRead, rdPending<=1 and rdOwner<=idx. Next cycle:
//   - mReadValid[rdOwner] = sReadValid & rdPending.
//   - mDataOut = sDataIn.
//   - back-to-back reads from different masters are legal every cycle.
//  Lock FSM, states IDLE/LOCKED:
//   - IDLE->LOCKED: granted transfer with mLock[idx]=1; lockOwner<=idx.
//   - LOCKED: only lockOwner may be granted; all other requesters see waitRequest=1.
//   - LOCKED->IDLE (a): owner transfer with mLock=0. That transfer still completes; next cycle is open.
//   - LOCKED->IDLE (b): mLock[owner]=0 while the owner is not requesting.
//   - LOCKED->IDLE (c): idleCnt reaches LOCK_TIMEOUT. idleCnt counts consecutive owner no-request
//     cycles, saturates, and clears on any owner transfer. Forced release pulses lockTimeout for 1 cycle
//     (internal status, exposed to the bench by hierarchy).
//  Simultaneous events: release and a new lock request in the same cycle are resolved by round-robin
//  in the next cycle; ptr already points past the old owner.
// STRUCTURE
//  avalon_arb_pkg: ADDR_W=2, DATA_W=32, typedef enum logic {IDLE, LOCKED} arbState_t.
//  Sub-module rr_grant: parameterised one-hot round-robin picker (req, ptr -> grant, idx).
//  Top level holds ptr, the lock FSM, idleCnt and the read-owner pipeline register.
// TESTING
//  1. Reset, then M0 and M1 both read addr0 every cycle:
//     grants alternate M0,M1,M0,...; each mReadValid arrives 1 cycle later at the right master.
//  2. M1 alone writes 0x0000_0005 to addr1: mWaitRequest[1]=0 in the same cycle;
//     sWrite=1, sAddress=1, sDataOut=5.
//  3. M0 locks, reads addr1, idles 3 cycles, then writes with mLock=0 while M1 requests throughout:
//     M1 is stalled until the cycle after M0's write.
//  4. M0 locks, then goes idle with mLock held: release occurs at idle cycle 16,
//     lockTimeout pulses once, M1 is granted the next cycle.
//  5. M0 asserts mRead and mWrite together: only sWrite=1; no mReadValid follows.
//  6. Assert resetN=0 the cycle after a read is issued: mReadValid stays 0;
//     after release, M0 wins first.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared widths and lock-FSM state type for the Avalon-MM arbiter.
//   ADDR_W      : slave word address width
//   DATA_W      : slave data width
//   arbState_t  : lock FSM states (IDLE = open arbitration, LOCKED = owner only)
package avalon_arb_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arbState_t;

endpackage

// File: rtl/rr_grant.sv
// One-hot round-robin picker: the first requester after ptr (mod N) wins.
//   req   : request vector
//   ptr   : index of the last granted requester
//   grant : one-hot grant, zero when nobody requests
//   idx   : binary index of the granted requester (0 when none)
//   valid : a grant was issued
module rr_grant #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int unsigned cand;

    // Scan ptr+1 .. ptr+N so the previous winner has the lowest priority
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
        if (valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave port (1-cycle read latency)
// between NUM_MASTERS requesters, with per-master lock for atomic sequences.
//   clk, resetN          : clock, asynchronous active-low reset
//   mRead/mWrite         : per-master strobes (write wins if both set)
//   mAddress/mDataIn     : per-master address and write data
//   mLock                : hold grant across consecutive transfers
//   mWaitRequest         : request not accepted this cycle (combinational)
//   mReadValid/mDataOut  : read return, routed to the issuing master
//   sRead/sWrite/...     : muxed request to the slave (combinational)
//   sReadValid/sDataIn   : slave read return
//   sIrq/irq             : interrupt passthrough
module avalon_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic [NUM_MASTERS-1:0]              mRead,
    input  logic [NUM_MASTERS-1:0]              mWrite,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  mAddress,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  mDataIn,
    input  logic [NUM_MASTERS-1:0]              mLock,
    output logic [NUM_MASTERS-1:0]              mWaitRequest,
    output logic [NUM_MASTERS-1:0]              mReadValid,
    output logic [DATA_W-1:0]                   mDataOut,
    output logic                                sRead,
    output logic                                sWrite,
    output logic [ADDR_W-1:0]                   sAddress,
    output logic [DATA_W-1:0]                   sDataOut,
    input  logic                                sReadValid,
    input  logic [DATA_W-1:0]                   sDataIn,
    input  logic                                sIrq,
    output logic                                irq
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arbState_t          state,       stateNext;
    logic [IDX_W-1:0]   ptr,         ptrNext;
    logic [IDX_W-1:0]   lockOwner,   lockOwnerNext;
    logic [CNT_W-1:0]   idleCnt,     idleCntNext;
    logic               lockTimeout, lockTimeoutNext;
    logic               rdPending,   rdPendingNext;
    logic [IDX_W-1:0]   rdOwner,     rdOwnerNext;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] ownerMask;
    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grantIdx;
    logic                   grantValid;
    logic                   ownerReq;
    logic                   ownerLock;
    logic [CNT_W-1:0]       idleInc;

    assign req = mRead | mWrite;

    // While locked, only the owner's request reaches the picker
    always_comb begin
        ownerMask            = '0;
        ownerMask[lockOwner] = 1'b1;
        eligible             = (state == LOCKED) ? (req & ownerMask) : req;
    end

    rr_grant #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_grant (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grantIdx),
        .valid (grantValid)
    );

    assign mWaitRequest = req & ~grant;
    assign irq          = sIrq;

    // Slave request mux; write takes precedence over a simultaneous read
    always_comb begin
        sRead    = 1'b0;
        sWrite   = 1'b0;
        sAddress = '0;
        sDataOut = '0;
        if (grantValid) begin
            sWrite   = mWrite[grantIdx];
            sRead    = mRead[grantIdx] & ~mWrite[grantIdx];
            sAddress = mAddress[grantIdx];
            sDataOut = mDataIn[grantIdx];
        end
    end

    // Read return routed to whoever issued the read one cycle earlier
    always_comb begin
        mReadValid          = '0;
        mReadValid[rdOwner] = sReadValid & rdPending;
        mDataOut            = sDataIn;
    end

    assign ownerReq  = req[lockOwner];
    assign ownerLock = mLock[lockOwner];
    assign idleInc   = (idleCnt == CNT_W'(LOCK_TIMEOUT)) ? idleCnt : idleCnt + CNT_W'(1);

    // Next-state: pointer, read pipeline and lock FSM
    always_comb begin
        stateNext       = state;
        ptrNext         = ptr;
        lockOwnerNext   = lockOwner;
        idleCntNext     = idleCnt;
        lockTimeoutNext = 1'b0;
        rdPendingNext   = sRead;
        rdOwnerNext     = rdOwner;

        if (grantValid) begin
            ptrNext = grantIdx;
        end
        if (sRead) begin
            rdOwnerNext = grantIdx;
        end

        case (state)
            IDLE: begin
                if (grantValid && mLock[grantIdx]) begin
                    stateNext     = LOCKED;
                    lockOwnerNext = grantIdx;
                    idleCntNext   = '0;
                end
            end
            LOCKED: begin
                if (ownerReq) begin
                    // Owner is the only eligible requester, so it is granted
                    idleCntNext = '0;
                    if (!ownerLock) begin
                        stateNext = IDLE;
                    end
                end else if (!ownerLock) begin
                    stateNext   = IDLE;
                    idleCntNext = '0;
                end else if (idleInc == CNT_W'(LOCK_TIMEOUT)) begin
                    // Forced release on the LOCK_TIMEOUT-th idle cycle
                    stateNext       = IDLE;
                    idleCntNext     = '0;
                    lockTimeoutNext = 1'b1;
                end else begin
                    idleCntNext = idleInc;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            ptr         <= IDX_W'(NUM_MASTERS - 1);
            lockOwner   <= '0;
            idleCnt     <= '0;
            lockTimeout <= 1'b0;
            rdPending   <= 1'b0;
            rdOwner     <= '0;
        end else begin
            state       <= stateNext;
            ptr         <= ptrNext;
            lockOwner   <= lockOwnerNext;
            idleCnt     <= idleCntNext;
            lockTimeout <= lockTimeoutNext;
            rdPending   <= rdPendingNext;
            rdOwner     <= rdOwnerNext;
        end
    end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Self-checking bench for avalon_arbiter (2 masters, LOCK_TIMEOUT=16).
module tb_avalon_arbiter;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0000;

    logic             clk = 1'b0;
    logic             resetN;
    logic [1:0]       mRead, mWrite, mLock;
    logic [1:0][1:0]  mAddress;
    logic [1:0][31:0] mDataIn;
    logic [1:0]       mWaitRequest, mReadValid;
    logic [31:0]      mDataOut;
    logic             sRead, sWrite;
    logic [1:0]       sAddress;
    logic [31:0]      sDataOut;
    logic             sReadValid = 1'b0;
    logic [31:0]      sDataIn = 32'h0;
    logic             sIrq, irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  rd, wr, lk, a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  ew;
        logic        esr, esw;
        logic [1:0]  ea;
        logic [31:0] ed;
        int unsigned ei;
        logic        elto;
    } vec_t;

    typedef struct packed {
        int unsigned owner;
        logic [31:0] data;
    } rv_t;

    rv_t  q[$];
    vec_t tbl[19];
    vec_t v;

    always #5 clk = ~clk;

    avalon_arbiter #(.NUM_MASTERS(2), .LOCK_TIMEOUT(16)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .mRead        (mRead),
        .mWrite       (mWrite),
        .mAddress     (mAddress),
        .mDataIn      (mDataIn),
        .mLock        (mLock),
        .mWaitRequest (mWaitRequest),
        .mReadValid   (mReadValid),
        .mDataOut     (mDataOut),
        .sRead        (sRead),
        .sWrite       (sWrite),
        .sAddress     (sAddress),
        .sDataOut     (sDataOut),
        .sReadValid   (sReadValid),
        .sDataIn      (sDataIn),
        .sIrq         (sIrq),
        .irq          (irq)
    );

    function automatic logic [31:0] rom(input logic [1:0] a);
        return 32'hC0DE_0010 + 32'(a);
    endfunction

    // Slave: fixed 1-cycle read latency, contents from rom()
    always @(posedge clk) begin
        sReadValid <= sRead;
        sDataIn    <= rom(sAddress);
    end

    function automatic vec_t mk(input logic [1:0] rd, input logic [1:0] wr, input logic [1:0] lk,
                                input logic [1:0] a0, input logic [1:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] ew, input logic esr, input logic esw,
                                input logic [1:0] ea, input logic [31:0] ed, input int unsigned ei);
        vec_t r;
        r.rd = rd; r.wr = wr; r.lk = lk; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
        r.ew = ew; r.esr = esr; r.esw = esw; r.ea = ea; r.ed = ed; r.ei = ei; r.elto = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rv(input string tag);
        rv_t        e;
        logic [1:0] oh;
        if (q.size() != 0) begin
            e  = q.pop_front();
            oh = 2'b01 << e.owner;
            chk({tag, ".rvalid"}, 32'(mReadValid), 32'(oh));
            chk({tag, ".rdata"}, mDataOut, e.data);
        end else begin
            chk({tag, ".rvalid_idle"}, 32'(mReadValid), 32'h0);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        rv_t e;
        @(negedge clk);
        mRead = x.rd; mWrite = x.wr; mLock = x.lk;
        mAddress[0] = x.a0; mAddress[1] = x.a1;
        mDataIn[0] = x.d0; mDataIn[1] = x.d1;
        sIrq = 1'($urandom_range(0, 1));
        #1;
        check_rv(tag);
        chk({tag, ".wait"},  32'(mWaitRequest), 32'(x.ew));
        chk({tag, ".sread"}, 32'(sRead), 32'(x.esr));
        chk({tag, ".swrite"}, 32'(sWrite), 32'(x.esw));
        chk({tag, ".saddr"}, 32'(sAddress), 32'(x.ea));
        chk({tag, ".sdata"}, sDataOut, x.ed);
        chk({tag, ".lto"},   32'(dut.lockTimeout), 32'(x.elto));
        chk({tag, ".irq"},   32'(irq), 32'(sIrq));
        if (x.esr) begin
            e.owner = x.ei;
            e.data  = rom(x.ea);
            q.push_back(e);
        end
    endtask

    task automatic drive_idle();
        mRead = 2'b00; mWrite = 2'b00; mLock = 2'b00;
        mAddress = '0; mDataIn = '0; sIrq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("reset.rvalid", 32'(mReadValid), 32'h0);
        chk("reset.lto", 32'(dut.lockTimeout), 32'h0);
        chk("reset.ptr", 32'(dut.ptr), 32'h1);
        chk("reset.state", 32'(dut.state), 32'h0);
        @(negedge clk);
        resetN = 1'b1;

        // rd     wr     lk     a0     a1     d0            d1            ew     esr   esw   ea     ed            ei
        tbl[0]  = mk(2'b11, 2'b00, 2'b00, 2'd0, 2'd0, D0, D1, 2'b10, 1'b1, 1'b0, 2'd0, D0, 0);
        tbl[1]  = mk(2'b11, 2'b00, 2'b00, 2'd0, 2'd0, D0, D1, 2'b01, 1'b1, 1'b0, 2'd0, D1, 1);
        tbl[2]  = tbl[0];
        tbl[3]  = tbl[1];
        tbl[4]  = mk(2'b00, 2'b10, 2'b00, 2'd0, 2'd1, D0, 32'd5, 2'b00, 1'b0, 1'b1, 2'd1, 32'd5, 1);
        tbl[5]  = mk(2'b01, 2'b01, 2'b00, 2'd2, 2'd0, 32'hDEAD_BEEF, D1, 2'b00, 1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF, 0);
        tbl[6]  = mk(2'b00, 2'b00, 2'b00, 2'd3, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0, 2'd0, 32'h0, 0);
        tbl[7]  = mk(2'b10, 2'b00, 2'b00, 2'd0, 2'd3, D0, D1, 2'b00, 1'b1, 1'b0, 2'd3, D1, 1);
        tbl[8]  = mk(2'b11, 2'b00, 2'b01, 2'd1, 2'd2, D0, D1, 2'b10, 1'b1, 1'b0, 2'd1, D0, 0);
        tbl[9]  = mk(2'b10, 2'b00, 2'b01, 2'd1, 2'd2, D0, D1, 2'b10, 1'b0, 1'b0, 2'd0, 32'h0, 0);
        tbl[10] = tbl[9];
        tbl[11] = tbl[9];
        tbl[12] = mk(2'b10, 2'b01, 2'b00, 2'd3, 2'd2, 32'h1234_5678, D1, 2'b10, 1'b0, 1'b1, 2'd3, 32'h1234_5678, 0);
        tbl[13] = mk(2'b11, 2'b00, 2'b00, 2'd1, 2'd2, D0, D1, 2'b01, 1'b1, 1'b0, 2'd2, D1, 1);
        tbl[14] = mk(2'b00, 2'b00, 2'b00, 2'd0, 2'd0, D0, D1, 2'b00, 1'b0, 1'b0, 2'd0, 32'h0, 0);
        tbl[15] = mk(2'b00, 2'b01, 2'b01, 2'd0, 2'd1, D0, D1, 2'b00, 1'b0, 1'b1, 2'd0, D0, 0);
        tbl[16] = mk(2'b10, 2'b00, 2'b00, 2'd0, 2'd1, D0, D1, 2'b10, 1'b0, 1'b0, 2'd0, 32'h0, 0);
        tbl[17] = mk(2'b10, 2'b00, 2'b00, 2'd0, 2'd1, D0, D1, 2'b00, 1'b1, 1'b0, 2'd1, D1, 1);
        tbl[18] = tbl[14];

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Lock timeout: M0 locks then idles with mLock held while M1 waits
        apply(mk(2'b10, 2'b01, 2'b01, 2'd0, 2'd0, D0, D1, 2'b10, 1'b0, 1'b1, 2'd0, D0, 0), "to.lock");
        for (int i = 1; i <= 16; i++) begin
            apply(mk(2'b10, 2'b00, 2'b01, 2'd0, 2'd0, D0, D1, 2'b10, 1'b0, 1'b0, 2'd0, 32'h0, 0),
                  $sformatf("to.idle%0d", i));
        end
        v = mk(2'b10, 2'b00, 2'b01, 2'd0, 2'd0, D0, D1, 2'b00, 1'b1, 1'b0, 2'd0, D1, 1);
        v.elto = 1'b1;
        apply(v, "to.release");
        apply(mk(2'b00, 2'b00, 2'b00, 2'd0, 2'd0, D0, D1, 2'b00, 1'b0, 1'b0, 2'd0, 32'h0, 0), "to.after");

        // Reset with a read in flight: the return is dropped and ptr restarts
        apply(mk(2'b01, 2'b00, 2'b00, 2'd2, 2'd0, D0, D1, 2'b00, 1'b1, 1'b0, 2'd2, D0, 0), "rst.read");
        @(negedge clk);
        resetN = 1'b0;
        drive_idle();
        q.delete();
        #1;
        chk("rst.rvalid", 32'(mReadValid), 32'h0);
        chk("rst.lto", 32'(dut.lockTimeout), 32'h0);
        chk("rst.ptr", 32'(dut.ptr), 32'h1);
        @(negedge clk);
        resetN = 1'b1;
        apply(mk(2'b11, 2'b00, 2'b00, 2'd0, 2'd0, D0, D1, 2'b10, 1'b1, 1'b0, 2'd0, D0, 0), "rst.first");
        apply(mk(2'b00, 2'b00, 2'b00, 2'd0, 2'd0, D0, D1, 2'b00, 1'b0, 1'b0, 2'd0, 32'h0, 0), "rst.ret");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
